// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch front end and the IF/ID pipeline register.
package fetch_unit_pkg;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } fq_entry_t;

  typedef struct packed {
    logic      valid;
    fq_entry_t entry;
  } if_id_reg_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Redirect, instruction-memory and decode handshake signals of the fetch unit.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             id_ready;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;

  modport master (
    input  redirect_valid, redirect_pc, id_ready, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, id_ready, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Small synchronous FIFO of fetched (pc, instr) pairs; clear dominates push.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  fq_entry_t              wdata,
  output fq_entry_t              rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             wrEn;
  logic             rdEn;

  assign wrEn = push && !clear;
  assign rdEn = pop && !clear && (count_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (wrEn) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (rdEn) rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(wrEn) - CNT_W'(rdEn);
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem_q[wrPtr_q] <= wdata;
  end

  assign rdata = mem_q[rdPtr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, memory issue, epoch-tagged response capture and queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              FQ_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_unit_if.master       bus
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             inFlight_q, inFlight_d;
  logic             epoch_q, epoch_d;
  logic             flightEpoch_q, flightEpoch_d;
  logic [PC_W-1:0]  flightPc_q, flightPc_d;

  logic             qClear, qPush, qPop, qEmpty, qFull;
  logic [CNT_W-1:0] qCount;
  fq_entry_t        qWdata, qRdata;
  logic             ifValid, deq, issue;
  logic [OCC_W-1:0] occupancy;

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .clear (qClear),
    .push  (qPush),
    .pop   (qPop),
    .wdata (qWdata),
    .rdata (qRdata),
    .count (qCount),
    .empty (qEmpty),
    .full  (qFull)
  );

  // Requests are only issued when a slot is guaranteed for the response.
  always_comb begin
    ifValid   = !qEmpty && !bus.redirect_valid;
    deq       = ifValid && bus.id_ready;
    occupancy = OCC_W'(qCount) + OCC_W'(inFlight_q) - OCC_W'(deq);
    issue     = !reset && !bus.redirect_valid && (occupancy < OCC_W'(FQ_DEPTH));
    qClear    = bus.redirect_valid;
    qPop      = deq;
    qPush     = inFlight_q && (flightEpoch_q == epoch_q) && !bus.redirect_valid;
    qWdata    = '{pc: flightPc_q, instr: bus.imem_rdata};
  end

  always_comb begin
    pc_d          = pc_q;
    epoch_d       = epoch_q;
    inFlight_d    = issue;
    flightEpoch_d = epoch_q;
    flightPc_d    = pc_q;
    if (bus.redirect_valid) begin
      pc_d    = {bus.redirect_pc[PC_W-1:2], 2'b00};
      epoch_d = ~epoch_q;
    end else if (issue) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      epoch_q       <= 1'b0;
      inFlight_q    <= 1'b0;
      flightEpoch_q <= 1'b0;
      flightPc_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      epoch_q       <= epoch_d;
      inFlight_q    <= inFlight_d;
      flightEpoch_q <= flightEpoch_d;
      flightPc_q    <= flightPc_d;
    end
  end

  // An empty queue presents all-zero fields so decode sees a bubble.
  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = ifValid;
  assign bus.if_pc     = qEmpty ? '0 : qRdata.pc;
  assign bus.if_instr  = qEmpty ? '0 : qRdata.instr;

endmodule
